// File: rtl/sdf_combine.sv
// Aligns NUM_CH primitive distance pipelines and folds them through a registered min/max chain.
// Optional difference mode (op 10, channels 1..N-1 negated) is built only with `SDF_COMBINE_DIFF_EN.
module sdf_combine #(
  parameter int                  NUM_CH = 2,
  parameter logic [5*NUM_CH-1:0] CH_LAT = {5'd11, 5'd9}
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 i_valid,
  input  logic [1:0]           i_op,
  input  logic [27*NUM_CH-1:0] i_dist,
  output logic                 o_valid,
  output logic [26:0]          o_dist,
  output logic [1:0]           o_id
);

  function automatic int lat_of(input int ch);
    return int'(CH_LAT[5*ch +: 5]);
  endfunction

  function automatic int max_lat();
    int m;
    m = 0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (lat_of(i) > m) m = lat_of(i);
    end
    return m;
  endfunction

  localparam int MAX_LAT  = max_lat();
  localparam int PIPE_LEN = MAX_LAT + NUM_CH - 1;
  localparam int OP_LEN   = (PIPE_LEN > 1) ? PIPE_LEN - 1 : 1;

  // Strict a < b; signed-magnitude order, with +0 and -0 treated as equal.
  function automatic logic dist_lt(input logic [26:0] a, input logic [26:0] b);
    if ((a[25:0] == 26'd0) && (b[25:0] == 26'd0)) return 1'b0;
    if (a[26] != b[26]) return a[26];
    if (!a[26]) return a[25:0] < b[25:0];
    return a[25:0] > b[25:0];
  endfunction

  logic [26:0] aligned [NUM_CH];
  logic [26:0] chain_d [NUM_CH];
  logic [1:0]  chain_i [NUM_CH];
  logic        vld_q   [PIPE_LEN];
  logic [1:0]  op_q    [OP_LEN];
  logic [1:0]  op_tap  [OP_LEN+1];

  // Channel k>0 gets k-1 extra stages so it meets the chain at fold stage k.
  for (genvar c = 0; c < NUM_CH; c++) begin : g_align
    localparam int DLY = MAX_LAT - lat_of(c) + ((c > 0) ? c - 1 : 0);
    if (DLY == 0) begin : g_pass
      assign aligned[c] = i_dist[27*c +: 27];
    end else begin : g_dly
      logic [26:0] dly_q [DLY];
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int j = 0; j < DLY; j++) dly_q[j] <= '0;
        end else begin
          dly_q[0] <= i_dist[27*c +: 27];
          for (int j = 1; j < DLY; j++) dly_q[j] <= dly_q[j-1];
        end
      end
      assign aligned[c] = dly_q[DLY-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int j = 0; j < PIPE_LEN; j++) vld_q[j] <= 1'b0;
      for (int j = 0; j < OP_LEN; j++)   op_q[j]  <= 2'b00;
    end else begin
      vld_q[0] <= i_valid;
      op_q[0]  <= i_op;
      for (int j = 1; j < PIPE_LEN; j++) vld_q[j] <= vld_q[j-1];
      for (int j = 1; j < OP_LEN; j++)   op_q[j]  <= op_q[j-1];
    end
  end

  // op_tap[m] is the op of the launch whose fold happens at the coming edge, m cycles after launch.
  assign op_tap[0] = i_op;
  for (genvar j = 1; j <= OP_LEN; j++) begin : g_op_tap
    assign op_tap[j] = op_q[j-1];
  end

  assign chain_d[0] = aligned[0];
  assign chain_i[0] = 2'd0;

  for (genvar k = 1; k < NUM_CH; k++) begin : g_stage
    logic [1:0]  stage_op;
    logic [26:0] cand;
    logic        take;
    logic [26:0] acc_d;
    logic [1:0]  acc_i;

    assign stage_op = op_tap[MAX_LAT + k - 1];

    always_comb begin
      cand = aligned[k];
      take = 1'b0;
`ifdef SDF_COMBINE_DIFF_EN
      if (stage_op == 2'b10) cand = {~aligned[k][26], aligned[k][25:0]};
      if ((stage_op == 2'b01) || (stage_op == 2'b10)) take = dist_lt(chain_d[k-1], cand);
      else                                             take = dist_lt(cand, chain_d[k-1]);
`else
      if (stage_op == 2'b01) take = dist_lt(chain_d[k-1], cand);
      else                   take = dist_lt(cand, chain_d[k-1]);
`endif
    end

    // Ties keep the running result, so the lowest channel index wins.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        acc_d <= '0;
        acc_i <= 2'd0;
      end else begin
        acc_d <= take ? cand : chain_d[k-1];
        acc_i <= take ? 2'(k) : chain_i[k-1];
      end
    end

    assign chain_d[k] = acc_d;
    assign chain_i[k] = acc_i;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_valid <= 1'b0;
      o_dist  <= '0;
      o_id    <= 2'd0;
    end else begin
      o_valid <= vld_q[PIPE_LEN-1];
      if (vld_q[PIPE_LEN-1]) begin
        o_dist <= chain_d[NUM_CH-1];
        o_id   <= chain_i[NUM_CH-1];
      end
    end
  end

endmodule

// File: tb/tb_sdf_combine.sv
// Directed bench for sdf_combine: a 2-channel {11,9} instance and a 4-channel {1,4,0,3} instance.
module tb_sdf_combine;
  localparam int NSTEP = 72;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        a_valid, b_valid;
  logic [1:0]  a_op, b_op;
  logic [53:0] a_dist;
  logic [107:0] b_dist;
  logic        a_o_valid, b_o_valid;
  logic [26:0] a_o_dist, b_o_dist;
  logic [1:0]  a_o_id, b_o_id;

  sdf_combine u_a (
    .clk(clk), .rst_n(rst_n), .i_valid(a_valid), .i_op(a_op), .i_dist(a_dist),
    .o_valid(a_o_valid), .o_dist(a_o_dist), .o_id(a_o_id)
  );

  sdf_combine #(.NUM_CH(4), .CH_LAT({5'd1, 5'd4, 5'd0, 5'd3})) u_b (
    .clk(clk), .rst_n(rst_n), .i_valid(b_valid), .i_op(b_op), .i_dist(b_dist),
    .o_valid(b_o_valid), .o_dist(b_o_dist), .o_id(b_o_id)
  );

  // Per-step input schedules and expected outputs (step s: inputs applied before posedge s).
  logic        a_vs [NSTEP];
  logic [1:0]  a_os [NSTEP];
  logic [26:0] a_ds [2][NSTEP];
  logic        a_ev [NSTEP];
  logic [26:0] a_ed [NSTEP];
  logic [1:0]  a_ei [NSTEP];
  logic        b_vs [NSTEP];
  logic [1:0]  b_os [NSTEP];
  logic [26:0] b_ds [4][NSTEP];
  logic        b_ev [NSTEP];
  logic [26:0] b_ed [NSTEP];
  logic [1:0]  b_ei [NSTEP];
  int          b_lat [4] = '{3, 0, 4, 1};

  int checks = 0;
  int errors = 0;
  logic [26:0] ha_d, hb_d;
  logic [1:0]  ha_i, hb_i;

  task automatic launch_a(input int t, input logic [1:0] op, input logic [26:0] d0, input logic [26:0] d1,
                          input bit chk, input logic [26:0] ed, input logic [1:0] ei);
    a_vs[t] = 1'b1;
    a_os[t] = op;
    a_ds[0][t+9]  = d0;
    a_ds[1][t+11] = d1;
    if (chk) begin
      a_ev[t+13] = 1'b1;
      a_ed[t+13] = ed;
      a_ei[t+13] = ei;
    end
  endtask

  task automatic launch_b(input int t, input logic [1:0] op, input logic [26:0] d0, input logic [26:0] d1,
                          input logic [26:0] d2, input logic [26:0] d3,
                          input bit chk, input logic [26:0] ed, input logic [1:0] ei);
    b_vs[t] = 1'b1;
    b_os[t] = op;
    b_ds[0][t+b_lat[0]] = d0;
    b_ds[1][t+b_lat[1]] = d1;
    b_ds[2][t+b_lat[2]] = d2;
    b_ds[3][t+b_lat[3]] = d3;
    if (chk) begin
      b_ev[t+8] = 1'b1;
      b_ed[t+8] = ed;
      b_ei[t+8] = ei;
    end
  endtask

  initial begin
    for (int s = 0; s < NSTEP; s++) begin
      a_vs[s] = 1'b0; a_os[s] = 2'b00; a_ev[s] = 1'b0; a_ed[s] = '0; a_ei[s] = 2'd0;
      b_vs[s] = 1'b0; b_os[s] = 2'b00; b_ev[s] = 1'b0; b_ed[s] = '0; b_ei[s] = 2'd0;
      for (int c = 0; c < 2; c++) a_ds[c][s] = s[0] ? 27'h7ffffff : 27'h3ffffff;
      for (int c = 0; c < 4; c++) b_ds[c][s] = s[0] ? 27'h3ffffff : 27'h7ffffff;
    end

    // Two-channel vectors: union, intersection, difference, zero tie, reserved op, negatives.
    launch_a(2, 2'b00, 27'h1fc0000, 27'h2000000, 1, 27'h1fc0000, 2'd0);
    launch_a(3, 2'b01, 27'h5fc0000, 27'h1fd3333, 1, 27'h1fd3333, 2'd1);
`ifdef SDF_COMBINE_DIFF_EN
    launch_a(4, 2'b10, 27'h1fc0000, 27'h6040000, 1, 27'h2040000, 2'd1);
    launch_a(10, 2'b10, 27'h6000000, 27'h1fc0000, 1, 27'h5fc0000, 2'd1);
`else
    launch_a(4, 2'b10, 27'h1fc0000, 27'h6040000, 1, 27'h6040000, 2'd1);
    launch_a(10, 2'b10, 27'h6000000, 27'h1fc0000, 1, 27'h6000000, 2'd0);
`endif
    launch_a(5, 2'b00, 27'h0000000, 27'h4000000, 1, 27'h0000000, 2'd0);
    launch_a(6, 2'b11, 27'h2000000, 27'h1fc0000, 1, 27'h1fc0000, 2'd1);
    launch_a(7, 2'b01, 27'h5fc0000, 27'h6000000, 1, 27'h5fc0000, 2'd0);
    launch_a(8, 2'b00, 27'h5fc0000, 27'h6000000, 1, 27'h6000000, 2'd1);
    launch_a(9, 2'b01, 27'h2000000, 27'h2000000, 1, 27'h2000000, 2'd0);

    // Four-channel back-to-back launches with alternating ops.
    launch_b(20, 2'b00, 27'h2000000, 27'h1fc0000, 27'h2040000, 27'h1fd3333, 1, 27'h1fc0000, 2'd1);
    launch_b(21, 2'b01, 27'h5fc0000, 27'h2000000, 27'h6040000, 27'h2040000, 1, 27'h2040000, 2'd3);
    launch_b(22, 2'b00, 27'h1fc0000, 27'h1fc0000, 27'h5fc0000, 27'h5fc0000, 1, 27'h5fc0000, 2'd2);
    launch_b(23, 2'b01, 27'h6000000, 27'h6040000, 27'h4000000, 27'h0000000, 1, 27'h4000000, 2'd2);

    // Launches killed by reset at step 43, then fresh launches after release.
    launch_a(40, 2'b00, 27'h1fc0000, 27'h2000000, 0, 27'h0, 2'd0);
    launch_b(40, 2'b00, 27'h1fc0000, 27'h2000000, 27'h2040000, 27'h1fd3333, 0, 27'h0, 2'd0);
    launch_a(50, 2'b01, 27'h2000000, 27'h2040000, 1, 27'h2040000, 2'd1);
    launch_b(50, 2'b00, 27'h1fd3333, 27'h2000000, 27'h1fc0000, 27'h2040000, 1, 27'h1fc0000, 2'd2);

    rst_n = 1'b0;
    a_valid = 1'b0; a_op = 2'b00; a_dist = '0;
    b_valid = 1'b0; b_op = 2'b00; b_dist = '0;
    ha_d = '0; ha_i = 2'd0; hb_d = '0; hb_i = 2'd0;

    for (int s = 0; s < NSTEP; s++) begin
      @(negedge clk);
      if (s == 1 || s == 46) rst_n = 1'b1;
      if (s == 43) rst_n = 1'b0;
      a_valid = a_vs[s];
      a_op    = a_os[s];
      a_dist  = {a_ds[1][s], a_ds[0][s]};
      b_valid = b_vs[s];
      b_op    = b_os[s];
      b_dist  = {b_ds[3][s], b_ds[2][s], b_ds[1][s], b_ds[0][s]};
      #1;
      if (!rst_n) begin
        ha_d = '0; ha_i = 2'd0; hb_d = '0; hb_i = 2'd0;
      end else begin
        if (a_ev[s]) begin ha_d = a_ed[s]; ha_i = a_ei[s]; end
        if (b_ev[s]) begin hb_d = b_ed[s]; hb_i = b_ei[s]; end
      end

      checks++;
      assert (a_o_valid === a_ev[s]) else begin
        errors++; $error("FAIL a_valid step %0d: got %b expected %b", s, a_o_valid, a_ev[s]);
      end
      checks++;
      assert (a_o_dist === ha_d) else begin
        errors++; $error("FAIL a_dist step %0d: got %h expected %h", s, a_o_dist, ha_d);
      end
      checks++;
      assert (a_o_id === ha_i) else begin
        errors++; $error("FAIL a_id step %0d: got %0d expected %0d", s, a_o_id, ha_i);
      end
      checks++;
      assert (b_o_valid === b_ev[s]) else begin
        errors++; $error("FAIL b_valid step %0d: got %b expected %b", s, b_o_valid, b_ev[s]);
      end
      checks++;
      assert (b_o_dist === hb_d) else begin
        errors++; $error("FAIL b_dist step %0d: got %h expected %h", s, b_o_dist, hb_d);
      end
      checks++;
      assert (b_o_id === hb_i) else begin
        errors++; $error("FAIL b_id step %0d: got %0d expected %0d", s, b_o_id, hb_i);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
